spi_master_fifo: RTL and testbench
==================================

SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 8, meaning bits per SPI frame.
REQ-002 SHALL have parameter FIFOAddrWidth, default 2, meaning each FIFO depth is 2^FIFOAddrWidth (4).
REQ-003 SHALL have parameter SPPRWidth, default 4, meaning width of the prescaler preset.
REQ-004 SHALL have parameter SPRWidth, default 3, meaning width of the power-of-two divider exponent.
REQ-005 SHALL have a single clock and a synchronous, active-low reset.
REQ-006 Ports SHALL be exactly, as name direction width meaning:
  Clk_i  in  1  system clock, rising edge
  Reset_n_i  in  1  synchronous reset, active low
  CPOL_i  in  1  SCK idle level
  CPHA_i  in  1  0: sample on leading edge; 1: shift on leading edge
  LSBFE_i  in  1  1: LSB first; 0: MSB first
  SPPR_i  in  SPPRWidth  prescaler preset
  SPR_i  in  SPRWidth  divider exponent
  Write_i  in  1  push Data_i into TX FIFO
  Data_i  in  DataWidth  TX data
  ReadNext_i  in  1  pop RX FIFO head
  Data_o  out  DataWidth  RX FIFO head (show-ahead)
  FIFOFull_o  out  1  TX FIFO full
  FIFOEmpty_o  out  1  RX FIFO empty
  Transmission_o  out  1  engine busy
  SCK_o  out  1  SPI clock
  MOSI_o  out  1  SPI data out
  MISO_i  in  1  SPI data in

Function
REQ-007 Half-period H SHALL be (SPPR_i+1) << SPR_i clock cycles; the counter SHALL be wide enough for the maximum H without overflow.
REQ-008 CPOL/CPHA/LSBFE/SPPR/SPR SHALL be latched on entry to LOAD and held for that frame.
REQ-009 Write_i with FIFOFull_o=0 SHALL push Data_i; with FIFOFull_o=1 it SHALL be ignored and FIFO contents unchanged.
REQ-010 ReadNext_i with FIFOEmpty_o=0 SHALL pop; with FIFOEmpty_o=1 it SHALL be ignored.
REQ-011 Data_o SHALL reflect the RX FIFO head combinationally; its value is don't-care when FIFOEmpty_o=1.
REQ-012 FSM states SHALL be IDLE, LOAD and SHIFT. IDLE->LOAD when the TX FIFO is non-empty. LOAD: pop TX into the shift register, drive the first bit on MOSI_o, and wait H cycles. LOAD->SHIFT occurs after those H cycles.
REQ-013 SHIFT SHALL toggle SCK_o every H cycles for 2*DataWidth edges.
  - CPHA=0: sample MISO_i on odd edges; shift on even edges.
  - CPHA=1: shift on odd edges, except edge 1, which keeps the first bit; sample on even edges.
REQ-014 After the last edge, the received frame SHALL be pushed to the RX FIFO in the same cycle the FSM leaves SHIFT. The FSM SHALL go to LOAD if TX is non-empty, else to IDLE.
REQ-015 Transmission_o SHALL equal (state != IDLE).
  - Write_i in cycle N, engine idle, TX empty: Transmission_o SHALL be 1 from cycle N+2.
  - A frame SHALL occupy exactly (2*DataWidth+1)*H cycles in LOAD+SHIFT.
REQ-016 SCK_o SHALL equal CPOL in IDLE and LOAD; MOSI_o SHALL hold its last value in IDLE.
REQ-017 RX push while RX full and no pop SHALL drop the new frame and leave the FIFO unchanged.
REQ-018 RX push with simultaneous ReadNext_i while full SHALL pop and push, leaving occupancy full.
REQ-019 Simultaneous Write_i and a LOAD pop on a full TX FIFO SHALL ignore the write: fullness is evaluated before the pop.
REQ-020 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-021 Reset_n_i=0 at a rising edge SHALL force, from the next cycle:
  - state IDLE; both FIFOs empty (FIFOFull_o=0, FIFOEmpty_o=1); Transmission_o=0.
  - MOSI_o=0; SCK_o=CPOL_i; divider and bit counters zero.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no RX push, regardless of SCK phase.

Verification
REQ-023 SPPR=0, SPR=0 (H=1), CPOL=1, CPHA=1, LSBFE=0, write 0xA5 with MISO looped to MOSI:
  - 17-cycle frame; SCK shows 8 low pulses.
  - MOSI sequence 1,0,1,0,0,1,0,1.
  - Then FIFOEmpty_o=0 and Data_o=0xA5.
REQ-024 CPOL=0, CPHA=0, LSBFE=1, SPPR=2, SPR=1 (H=6), MISO driven with 0x3C LSB-first: 102-cycle frame; Data_o=0x3C.
REQ-025 Five writes 0x01..0x05 in consecutive cycles while idle:
  - FIFOFull_o rises only after the engine has popped 0x01 and the remaining writes have filled the FIFO; any write while FIFOFull_o=1 is lost.
  - The transmitted frames match the accepted writes, in order, back-to-back with Transmission_o continuously 1.
REQ-026 Six frames received with no ReadNext_i: the RX FIFO holds frames 1-4, frames 5-6 are dropped, and four pops return 1,2,3,4.
REQ-027 RX full, ReadNext_i asserted in the frame-completion cycle: occupancy stays 4 and the head advances to frame 2.
REQ-028 Reset pulsed at the 7th SCK edge: next cycle Transmission_o=0, FIFOEmpty_o=1, FIFOFull_o=0, SCK_o=CPOL_i.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with 4-entry TX and RX FIFOs and programmable SCK rate, polarity, phase and bit order.
// The FSM pops a TX word in LOAD, clocks 2*DataWidth SCK edges in SHIFT and pushes the received word.
module spi_master_fifo #(
    parameter int DataWidth     = 8,
    parameter int FIFOAddrWidth = 2,
    parameter int SPPRWidth     = 4,
    parameter int SPRWidth      = 3
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 CPOL_i,
    input  logic                 CPHA_i,
    input  logic                 LSBFE_i,
    input  logic [SPPRWidth-1:0] SPPR_i,
    input  logic [SPRWidth-1:0]  SPR_i,
    input  logic                 Write_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 ReadNext_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 FIFOFull_o,
    output logic                 FIFOEmpty_o,
    output logic                 Transmission_o,
    output logic                 SCK_o,
    output logic                 MOSI_o,
    input  logic                 MISO_i
);

    localparam int Depth = 1 << FIFOAddrWidth;
    localparam int PtrW  = FIFOAddrWidth + 1;
    localparam int CntW  = SPPRWidth + (1 << SPRWidth);
    localparam int EdgeW = $clog2(2 * DataWidth + 1);
    localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DataWidth - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    function automatic logic first_bit(input logic [DataWidth-1:0] d, input logic lsbfe);
        return lsbfe ? d[0] : d[DataWidth-1];
    endfunction

    function automatic logic [DataWidth-1:0] shift_out(input logic [DataWidth-1:0] d,
                                                       input logic lsbfe);
        return lsbfe ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [DataWidth-1:0] shift_in(input logic [DataWidth-1:0] d,
                                                      input logic b, input logic lsbfe);
        return lsbfe ? {b, d[DataWidth-1:1]} : {d[DataWidth-2:0], b};
    endfunction

    state_t                 state;
    logic [CntW-1:0]        div_cnt;
    logic [EdgeW-1:0]       edge_cnt;
    logic                   cpol_q, cpha_q, lsbfe_q;
    logic [SPPRWidth-1:0]   sppr_q;
    logic [SPRWidth-1:0]    spr_q;
    logic [DataWidth-1:0]   tx_sr, rx_sr;
    logic                   sck_q, mosi_q;

    logic [DataWidth-1:0]   tx_mem [Depth];
    logic [DataWidth-1:0]   rx_mem [Depth];
    logic [PtrW-1:0]        tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic                   tx_empty, tx_full, rx_empty, rx_full;
    logic                   tx_push, tx_pop, rx_push, rx_pop, rx_write;
    logic [DataWidth-1:0]   tx_head, rx_next;

    logic [CntW-1:0]        h_last;
    logic                   half_done, edge_odd, do_sample, do_shift, last_edge;

    // Extra pointer MSB separates full from empty when the address bits match
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[FIFOAddrWidth-1:0] == tx_rd_ptr[FIFOAddrWidth-1:0]) &&
                      (tx_wr_ptr[FIFOAddrWidth] != tx_rd_ptr[FIFOAddrWidth]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[FIFOAddrWidth-1:0] == rx_rd_ptr[FIFOAddrWidth-1:0]) &&
                      (rx_wr_ptr[FIFOAddrWidth] != rx_rd_ptr[FIFOAddrWidth]);
    assign tx_head  = tx_mem[tx_rd_ptr[FIFOAddrWidth-1:0]];

    assign h_last    = ((CntW'(sppr_q) + CntW'(1)) << spr_q) - CntW'(1);
    assign half_done = (div_cnt == h_last);
    assign edge_odd  = ~edge_cnt[0];
    assign do_sample = cpha_q ? ~edge_odd : edge_odd;
    assign do_shift  = cpha_q ? (edge_odd && edge_cnt != '0) : (~edge_odd && edge_cnt != LastEdge);
    assign last_edge = (state == SHIFT) && half_done && (edge_cnt == LastEdge);
    assign rx_next   = do_sample ? shift_in(rx_sr, MISO_i, lsbfe_q) : rx_sr;

    // Fullness is judged before this cycle's pop, so a write into a full FIFO is always dropped
    assign tx_push  = Write_i && !tx_full;
    assign tx_pop   = !tx_empty && ((state == IDLE) || last_edge);
    assign rx_push  = last_edge;
    assign rx_pop   = ReadNext_i && !rx_empty;
    assign rx_write = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge Clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr[FIFOAddrWidth-1:0]] <= Data_i;
        if (rx_write) rx_mem[rx_wr_ptr[FIFOAddrWidth-1:0]] <= rx_next;
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (tx_push)  tx_wr_ptr <= tx_wr_ptr + PtrW'(1);
            if (tx_pop)   tx_rd_ptr <= tx_rd_ptr + PtrW'(1);
            if (rx_write) rx_wr_ptr <= rx_wr_ptr + PtrW'(1);
            if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + PtrW'(1);
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            sck_q    <= CPOL_i;
            mosi_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsbfe_q  <= 1'b0;
            sppr_q   <= '0;
            spr_q    <= '0;
        end else begin
            case (state)
                IDLE: sck_q <= CPOL_i;
                LOAD: begin
                    if (half_done) begin
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + CntW'(1);
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        div_cnt  <= '0;
                        sck_q    <= ~sck_q;
                        edge_cnt <= edge_cnt + EdgeW'(1);
                        rx_sr    <= rx_next;
                        if (do_shift) begin
                            tx_sr  <= shift_out(tx_sr, lsbfe_q);
                            mosi_q <= first_bit(shift_out(tx_sr, lsbfe_q), lsbfe_q);
                        end
                        if (last_edge) begin
                            edge_cnt <= '0;
                            state    <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + CntW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // Starting a frame overrides the above, both from IDLE and back-to-back after SHIFT
            if (tx_pop) begin
                state    <= LOAD;
                div_cnt  <= '0;
                edge_cnt <= '0;
                sck_q    <= CPOL_i;
                cpol_q   <= CPOL_i;
                cpha_q   <= CPHA_i;
                lsbfe_q  <= LSBFE_i;
                sppr_q   <= SPPR_i;
                spr_q    <= SPR_i;
                tx_sr    <= tx_head;
                mosi_q   <= first_bit(tx_head, LSBFE_i);
            end
        end
    end

    assign Data_o         = rx_mem[rx_rd_ptr[FIFOAddrWidth-1:0]];
    assign FIFOFull_o     = tx_full;
    assign FIFOEmpty_o    = rx_empty;
    assign Transmission_o = (state != IDLE);
    assign SCK_o          = sck_q;
    assign MOSI_o         = mosi_q;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: a scoreboard queue holds expected RX words, checked as they are popped.
// MISO is looped back from MOSI, or driven by a small LSB-first mode-0 slave model.
module tb_spi_master_fifo;

    logic       Clk_i = 1'b0;
    logic       Reset_n_i, CPOL_i, CPHA_i, LSBFE_i;
    logic [3:0] SPPR_i;
    logic [2:0] SPR_i;
    logic       Write_i, ReadNext_i;
    logic [7:0] Data_i, Data_o;
    logic       FIFOFull_o, FIFOEmpty_o, Transmission_o, SCK_o, MOSI_o, MISO_i;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    int busy_cnt = 0;
    int rise_cnt = 0;
    int sck_fall = 0;
    int sck_rise = 0;
    int sck_tog  = 0;
    logic tr_q = 1'b0;
    logic [7:0] mosi_cap = '0;

    logic       slave_en = 1'b0;
    logic [7:0] slave_pat = '0;
    int         slave_base = 0;
    logic [2:0] slave_idx;

    assign slave_idx = 3'(sck_fall - slave_base);
    assign MISO_i    = slave_en ? slave_pat[slave_idx] : MOSI_o;

    spi_master_fifo dut (
        .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .CPOL_i(CPOL_i), .CPHA_i(CPHA_i),
        .LSBFE_i(LSBFE_i), .SPPR_i(SPPR_i), .SPR_i(SPR_i), .Write_i(Write_i),
        .Data_i(Data_i), .ReadNext_i(ReadNext_i), .Data_o(Data_o),
        .FIFOFull_o(FIFOFull_o), .FIFOEmpty_o(FIFOEmpty_o),
        .Transmission_o(Transmission_o), .SCK_o(SCK_o), .MOSI_o(MOSI_o), .MISO_i(MISO_i)
    );

    always #5 Clk_i = ~Clk_i;

    always @(negedge Clk_i) begin
        tr_q <= Transmission_o;
        if (Transmission_o) busy_cnt <= busy_cnt + 1;
        if (Transmission_o && !tr_q) rise_cnt <= rise_cnt + 1;
    end

    always @(negedge SCK_o) sck_fall <= sck_fall + 1;
    always @(posedge SCK_o) begin
        sck_rise <= sck_rise + 1;
        mosi_cap <= {mosi_cap[6:0], MOSI_o};
    end
    always @(SCK_o) sck_tog <= sck_tog + 1;

    task automatic step();
        @(negedge Clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic cpol, input logic cpha, input logic lsbfe,
                       input logic [3:0] sppr, input logic [2:0] spr);
        CPOL_i = cpol; CPHA_i = cpha; LSBFE_i = lsbfe; SPPR_i = sppr; SPR_i = spr;
        repeat (3) step();
    endtask

    task automatic write_byte(input logic [7:0] d);
        int i = 0;
        while (FIFOFull_o && i < 500) begin step(); i++; end
        chk("tx_space", FIFOFull_o, 1'b0);
        Write_i = 1'b1; Data_i = d;
        step();
        Write_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (Transmission_o && i < 2000) begin step(); i++; end
        chk({tag, "_idle"}, Transmission_o, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        int i = 0;
        logic [7:0] e;
        while (FIFOEmpty_o && i < 300) begin step(); i++; end
        chk({tag, "_rx_ready"}, FIFOEmpty_o, 1'b0);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk(tag, Data_o, e);
        ReadNext_i = 1'b1;
        step();
        ReadNext_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, f0, s0;
        Reset_n_i = 1'b0; CPOL_i = 1'b1; CPHA_i = 1'b0; LSBFE_i = 1'b0;
        SPPR_i = '0; SPR_i = '0; Write_i = 1'b0; Data_i = '0; ReadNext_i = 1'b0;
        repeat (3) step();
        chk("rst_trans", Transmission_o, 1'b0);
        chk("rst_empty", FIFOEmpty_o, 1'b1);
        chk("rst_full", FIFOFull_o, 1'b0);
        chk("rst_sck", SCK_o, 1'b1);
        chk("rst_mosi", MOSI_o, 1'b0);
        Reset_n_i = 1'b1;

        // Mode 3, MSB first, H=1, loopback of 0xA5
        cfg(1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
        b0 = busy_cnt; f0 = sck_fall; s0 = sck_rise;
        Write_i = 1'b1; Data_i = 8'hA5; sb.push_back(8'hA5);
        step();
        Write_i = 1'b0;
        chk("trans_n1", Transmission_o, 1'b0);
        step();
        chk("trans_n2", Transmission_o, 1'b1);
        wait_idle("a5");
        chk("a5_frame_len", busy_cnt - b0, 17);
        chk("a5_low_pulses", sck_fall - f0, 8);
        chk("a5_mosi_samples", sck_rise - s0, 8);
        chk("a5_mosi_seq", mosi_cap, 8'hA5);
        chk("a5_sck_idle", SCK_o, 1'b1);
        pop_check("a5_rx");
        chk("a5_rx_empty", FIFOEmpty_o, 1'b1);

        // Mode 0, LSB first, H=6, slave returns 0x3C
        cfg(1'b0, 1'b0, 1'b1, 4'd2, 3'd1);
        slave_base = sck_fall; slave_pat = 8'h3C; slave_en = 1'b1;
        b0 = busy_cnt;
        write_byte(8'h00); sb.push_back(8'h3C);
        step();
        wait_idle("h6");
        slave_en = 1'b0;
        chk("h6_frame_len", busy_cnt - b0, 102);
        pop_check("h6_rx");

        // Burst of writes while idle, H=1 mode 0 MSB first
        cfg(1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
        b0 = busy_cnt; r0 = rise_cnt;
        Write_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            Data_i = 8'(k);
            sb.push_back(8'(k));
            step();
            chk($sformatf("burst_full_%0d", k), FIFOFull_o, (k == 5));
        end
        Data_i = 8'h06;
        step();
        Write_i = 1'b0;
        repeat (12) step();
        chk("burst_full_before_pop", FIFOFull_o, 1'b1);
        Write_i = 1'b1; Data_i = 8'h07;
        step();
        Write_i = 1'b0;
        chk("burst_write_on_pop", FIFOFull_o, 1'b0);
        for (int k = 1; k <= 5; k++) pop_check($sformatf("burst_rx_%0d", k));
        wait_idle("burst");
        chk("burst_busy_cycles", busy_cnt - b0, 85);
        chk("burst_one_busy_span", rise_cnt - r0, 1);
        repeat (30) step();
        chk("burst_no_extra", FIFOEmpty_o, 1'b1);

        // Six frames without reads: only the first four are kept
        for (int k = 0; k < 6; k++) begin
            write_byte(8'h11 + 8'(k));
            if (k < 4) sb.push_back(8'h11 + 8'(k));
        end
        step();
        wait_idle("six");
        for (int k = 0; k < 4; k++) pop_check($sformatf("six_rx_%0d", k + 1));
        chk("six_dropped", FIFOEmpty_o, 1'b1);

        // RX full, pop in the completion cycle of frame 5 (mode 1, LSB first)
        cfg(1'b0, 1'b1, 1'b1, 4'd0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            write_byte(8'h21 + 8'(k));
            sb.push_back(8'h21 + 8'(k));
        end
        step();
        wait_idle("fill");
        write_byte(8'h25);
        repeat (17) step();
        chk("cc_still_busy", Transmission_o, 1'b1);
        chk("cc_head", Data_o, sb.pop_front());
        sb.push_back(8'h25);
        ReadNext_i = 1'b1;
        step();
        ReadNext_i = 1'b0;
        chk("cc_done", Transmission_o, 1'b0);
        for (int k = 0; k < 4; k++) pop_check($sformatf("cc_rx_%0d", k + 2));
        chk("cc_empty", FIFOEmpty_o, 1'b1);

        // Reset at the 7th SCK edge aborts the frame
        cfg(1'b1, 1'b0, 1'b0, 4'd1, 3'd0);
        s0 = sck_tog;
        write_byte(8'h5A);
        begin
            int i = 0;
            while ((sck_tog - s0) < 7 && i < 500) begin step(); i++; end
        end
        chk("abort_edge7", sck_tog - s0, 7);
        Reset_n_i = 1'b0;
        step();
        Reset_n_i = 1'b1;
        sb.delete();
        chk("abort_trans", Transmission_o, 1'b0);
        chk("abort_empty", FIFOEmpty_o, 1'b1);
        chk("abort_full", FIFOFull_o, 1'b0);
        chk("abort_sck", SCK_o, CPOL_i);
        chk("abort_mosi", MOSI_o, 1'b0);
        repeat (40) step();
        chk("abort_no_push", FIFOEmpty_o, 1'b1);
        chk("abort_stay_idle", Transmission_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
